// File: rtl/haraka_sponge_ctrl.sv
// haraka_sponge_ctrl
// Sponge-mode controller for a Haraka-style permutation core. It gathers
// message bytes into a RATE-bit block, pads the final block, sequences one
// permutation per block and then hands out SQUEEZE_BLOCKS squeezed blocks.
//
// Ports:
//   clk, clear         clock and asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready   byte stream in (valid/ready)
//   blk_out            block to the core, byte k at bits [8k+7:8k]
//   perm_start/perm_init/perm_absorb/perm_done   core handshake
//   sq_valid/sq_last/sq_ready   squeeze handshake
//   busy, blk_count    status (controller active, absorbed blocks)
module haraka_sponge_ctrl #(
  parameter int                  IN_WIDTH       = 8,
  parameter int                  RATE           = 256,
  parameter logic [IN_WIDTH-1:0] PAD_BEGINNING  = 8'h1f,
  parameter logic [IN_WIDTH-1:0] PAD_ENDING     = 8'h80,
  parameter int                  SQUEEZE_BLOCKS = 1
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [RATE-1:0]     blk_out,
  output logic                perm_start,
  output logic                perm_init,
  output logic                perm_absorb,
  input  logic                perm_done,
  output logic                sq_valid,
  output logic                sq_last,
  input  logic                sq_ready,
  output logic                busy,
  output logic [15:0]         blk_count
);

  localparam int BYTES = RATE / IN_WIDTH;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SQ_W  = $clog2(SQUEEZE_BLOCKS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(SQUEEZE_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ABSORB  = 3'd1,
    PAD     = 3'd2,
    PERM    = 3'd3,
    SQUEEZE = 3'd4
  } state_t;

  state_t                             state_r;
  logic [BYTES-1:0][IN_WIDTH-1:0]     buf_r;
  logic [BYTES-1:0][IN_WIDTH-1:0]     pad_blk_s;
  logic [IDX_W-1:0]                   byte_cnt_r;
  logic [IDX_W-1:0]                   idx_s;
  logic [SQ_W-1:0]                    sq_cnt_r;
  logic                               first_r;
  logic                               final_r;
  logic                               pend_pad_r;
  logic                               perm_start_r;
  logic                               perm_init_r;
  logic                               perm_absorb_r;
  logic                               sq_valid_r;
  logic                               sq_last_r;
  logic [15:0]                        blk_count_r;

  assign in_ready    = (state_r == IDLE) || (state_r == ABSORB);
  assign busy        = (state_r != IDLE);
  assign blk_out     = buf_r;
  assign perm_start  = perm_start_r;
  assign perm_init   = perm_init_r;
  assign perm_absorb = perm_absorb_r;
  assign sq_valid    = sq_valid_r;
  assign sq_last     = sq_last_r;
  assign blk_count   = blk_count_r;

  // Write position of the byte being accepted: a new message always starts at byte 0.
  always_comb begin
    idx_s = byte_cnt_r;
    if (state_r == IDLE) begin
      idx_s = '0;
    end else begin
      idx_s = byte_cnt_r;
    end
  end

  // Padded version of the buffer: first pad byte at byte_cnt, zeros above, end marker OR-ed into the top byte.
  always_comb begin
    pad_blk_s = buf_r;
    for (int i = 0; i < BYTES; i++) begin
      if (IDX_W'(i) == byte_cnt_r) begin
        pad_blk_s[i] = PAD_BEGINNING;
      end else if (IDX_W'(i) > byte_cnt_r) begin
        pad_blk_s[i] = '0;
      end else begin
        pad_blk_s[i] = buf_r[i];
      end
    end
    pad_blk_s[BYTES-1] = pad_blk_s[BYTES-1] | PAD_ENDING;
  end

  // Main sponge FSM with all outputs registered.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r       <= IDLE;
      buf_r         <= '0;
      byte_cnt_r    <= '0;
      sq_cnt_r      <= '0;
      first_r       <= 1'b0;
      final_r       <= 1'b0;
      pend_pad_r    <= 1'b0;
      perm_start_r  <= 1'b0;
      perm_init_r   <= 1'b0;
      perm_absorb_r <= 1'b0;
      sq_valid_r    <= 1'b0;
      sq_last_r     <= 1'b0;
      blk_count_r   <= 16'h0000;
    end else begin
      perm_start_r <= 1'b0;
      case (state_r)
        IDLE, ABSORB: begin
          if (in_valid) begin
            buf_r[idx_s] <= in_data;
            byte_cnt_r   <= (idx_s == LAST_IDX) ? '0 : idx_s + IDX_W'(1);
            if (state_r == IDLE) begin
              first_r <= 1'b1;
            end
            if (idx_s == LAST_IDX) begin
              // Full block: permute it first; a final byte here means padding goes in a block of its own.
              state_r       <= PERM;
              final_r       <= 1'b0;
              pend_pad_r    <= in_last;
              perm_start_r  <= 1'b1;
              perm_init_r   <= (state_r == IDLE) ? 1'b1 : first_r;
              perm_absorb_r <= 1'b1;
            end else if (in_last) begin
              state_r <= PAD;
            end else begin
              state_r <= ABSORB;
            end
          end
        end
        PAD: begin
          buf_r         <= pad_blk_s;
          state_r       <= PERM;
          final_r       <= 1'b1;
          perm_start_r  <= 1'b1;
          perm_init_r   <= first_r;
          perm_absorb_r <= 1'b1;
        end
        PERM: begin
          // perm_done is ignored during the start cycle so a stale level cannot end the new permutation.
          if (!perm_start_r && perm_done) begin
            first_r       <= 1'b0;
            perm_init_r   <= 1'b0;
            perm_absorb_r <= 1'b0;
            if (perm_absorb_r && (blk_count_r != 16'hffff)) begin
              blk_count_r <= blk_count_r + 16'd1;
            end
            if (pend_pad_r) begin
              buf_r      <= '0;
              byte_cnt_r <= '0;
              pend_pad_r <= 1'b0;
              state_r    <= PAD;
            end else if (!final_r) begin
              buf_r      <= '0;
              byte_cnt_r <= '0;
              state_r    <= ABSORB;
            end else begin
              state_r    <= SQUEEZE;
              sq_valid_r <= 1'b1;
              sq_last_r  <= (sq_cnt_r == SQ_LAST);
            end
          end
        end
        SQUEEZE: begin
          if (sq_ready) begin
            sq_valid_r <= 1'b0;
            sq_last_r  <= 1'b0;
            buf_r      <= '0;
            if (sq_last_r) begin
              state_r     <= IDLE;
              sq_cnt_r    <= '0;
              blk_count_r <= 16'h0000;
              first_r     <= 1'b0;
              final_r     <= 1'b0;
            end else begin
              // Further output block: permute an all-zero block without absorbing.
              sq_cnt_r      <= sq_cnt_r + SQ_W'(1);
              state_r       <= PERM;
              perm_start_r  <= 1'b1;
              perm_init_r   <= first_r;
              perm_absorb_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_haraka_sponge_ctrl.sv
// Scoreboard bench for haraka_sponge_ctrl: u_dut uses default parameters,
// u_dut2 uses SQUEEZE_BLOCKS=2. Stimulus pushes expected core/squeeze events,
// a monitor pops and compares them when the DUT presents them.
module tb_haraka_sponge_ctrl;

  logic         clk = 1'b0;
  logic         clear;
  logic [7:0]   in_data;
  logic         in_valid, in_valid2, in_last;
  logic         done_a, stray_a, done_b;
  logic         sq_ready, sq_ready2;
  logic         perm_done, perm_done2;
  logic         in_ready, in_ready2;
  logic [255:0] blk_out, blk_out2;
  logic         perm_start, perm_start2, perm_init, perm_init2, perm_absorb, perm_absorb2;
  logic         sq_valid, sq_valid2, sq_last, sq_last2, busy, busy2;
  logic [15:0]  blk_count, blk_count2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           dut;
    int           kind;   // 0 = permutation start, 1 = squeeze handshake
    logic [255:0] blk;
    logic         init;
    logic         absorb;
    logic         last;
    logic [15:0]  cnt;
  } ev_t;
  ev_t q[$];

  assign perm_done  = done_a | stray_a;
  assign perm_done2 = done_b;

  always #5 clk = ~clk;

  haraka_sponge_ctrl u_dut (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .blk_out(blk_out), .perm_start(perm_start), .perm_init(perm_init),
    .perm_absorb(perm_absorb), .perm_done(perm_done), .sq_valid(sq_valid), .sq_last(sq_last),
    .sq_ready(sq_ready), .busy(busy), .blk_count(blk_count)
  );

  haraka_sponge_ctrl #(.SQUEEZE_BLOCKS(2)) u_dut2 (
    .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid2), .in_last(in_last),
    .in_ready(in_ready2), .blk_out(blk_out2), .perm_start(perm_start2), .perm_init(perm_init2),
    .perm_absorb(perm_absorb2), .perm_done(perm_done2), .sq_valid(sq_valid2), .sq_last(sq_last2),
    .sq_ready(sq_ready2), .busy(busy2), .blk_count(blk_count2)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_p(input int d, input logic [255:0] b, input logic i, input logic a);
    ev_t e;
    e.dut = d; e.kind = 0; e.blk = b; e.init = i; e.absorb = a; e.last = 1'b0; e.cnt = 16'h0000;
    q.push_back(e);
  endtask

  task automatic push_s(input int d, input logic l, input logic [15:0] c);
    ev_t e;
    e.dut = d; e.kind = 1; e.blk = '0; e.init = 1'b0; e.absorb = 1'b0; e.last = l; e.cnt = c;
    q.push_back(e);
  endtask

  task automatic check_perm(input int id);
    ev_t e;
    chk("perm_expected", q.size() > 0, 1'b1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("perm_kind", e.kind, 0);
      chk("perm_dut", id, e.dut);
      chk("perm_blk", (id == 0) ? blk_out : blk_out2, e.blk);
      chk("perm_init", (id == 0) ? perm_init : perm_init2, e.init);
      chk("perm_absorb", (id == 0) ? perm_absorb : perm_absorb2, e.absorb);
    end
  endtask

  task automatic check_sq(input int id);
    ev_t e;
    chk("sq_expected", q.size() > 0, 1'b1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sq_kind", e.kind, 1);
      chk("sq_dut", id, e.dut);
      chk("sq_last", (id == 0) ? sq_last : sq_last2, e.last);
      chk("sq_blk_count", (id == 0) ? blk_count : blk_count2, e.cnt);
    end
  endtask

  // Monitor: compare every presented core start / squeeze handshake with the scoreboard.
  initial forever begin
    @(negedge clk);
    if (clear === 1'b0) begin
      if (perm_start === 1'b1)  check_perm(0);
      if (perm_start2 === 1'b1) check_perm(1);
      if (sq_valid === 1'b1 && sq_ready === 1'b1)   check_sq(0);
      if (sq_valid2 === 1'b1 && sq_ready2 === 1'b1) check_sq(1);
    end
  end

  // Core model for u_dut: perm_done three cycles after each start.
  initial forever begin
    @(negedge clk);
    if (perm_start === 1'b1) begin
      repeat (3) @(posedge clk);
      #1 done_a = 1'b1;
      @(posedge clk);
      #1 done_a = 1'b0;
    end
  end

  // Core model for u_dut2.
  initial forever begin
    @(negedge clk);
    if (perm_start2 === 1'b1) begin
      repeat (3) @(posedge clk);
      #1 done_b = 1'b1;
      @(posedge clk);
      #1 done_b = 1'b0;
    end
  end

  task automatic send(input logic [7:0] m[$], input int id);
    for (int i = 0; i < m.size(); i++) begin
      int b;
      b = 0;
      in_data = m[i];
      in_last = (i == m.size() - 1);
      if (id == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
      while (((id == 0) ? in_ready : in_ready2) !== 1'b1 && b < 100) begin
        @(posedge clk); #1; b++;
      end
      chk("in_ready_wait", b < 100, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
  endtask

  task automatic squeeze(input int id, input int hold, input bit fin);
    int b;
    b = 0;
    while (((id == 0) ? sq_valid : sq_valid2) !== 1'b1 && b < 200) begin
      @(posedge clk); #1; b++;
    end
    chk("sq_valid_wait", b < 200, 1'b1);
    for (int c = 0; c < hold; c++) begin
      if (c == 3 || c == 6) stray_a = 1'b1;
      @(posedge clk); #1;
      stray_a = 1'b0;
      chk("sq_hold_valid", sq_valid, 1'b1);
      chk("sq_hold_no_start", perm_start, 1'b0);
      chk("sq_hold_state", {busy, in_ready}, 2'b10);
    end
    if (id == 0) sq_ready = 1'b1; else sq_ready2 = 1'b1;
    @(posedge clk); #1;
    sq_ready = 1'b0; sq_ready2 = 1'b0;
    if (fin) chk("idle_after_sq", (id == 0) ? {busy, in_ready} : {busy2, in_ready2}, 2'b01);
  endtask

  task automatic chk_reset();
    chk("rst_blk_out", blk_out, '0);
    chk("rst_perm_start", perm_start, 1'b0);
    chk("rst_perm_init", perm_init, 1'b0);
    chk("rst_perm_absorb", perm_absorb, 1'b0);
    chk("rst_sq", {sq_valid, sq_last}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_blk_count", blk_count, 16'h0000);
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [7:0]   m[$];
    logic [255:0] e;
    int           b;
    clear = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    done_a = 1'b0; stray_a = 1'b0; done_b = 1'b0; sq_ready = 1'b0; sq_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset();
    clear = 1'b0;
    @(posedge clk); #1;

    // 3-byte message 01 02 03.
    e = '0; e[7:0] = 8'h01; e[15:8] = 8'h02; e[23:16] = 8'h03; e[31:24] = 8'h1f; e[255:248] = 8'h80;
    push_p(0, e, 1'b1, 1'b1); push_s(0, 1'b1, 16'd1);
    m = {8'h01, 8'h02, 8'h03};
    send(m, 0);
    squeeze(0, 0, 1'b1);

    // 30-byte message: pad start at byte 30, end marker alone in byte 31.
    m = {}; e = '0;
    for (int i = 0; i < 30; i++) begin m.push_back(8'(i + 1)); e[8*i +: 8] = 8'(i + 1); end
    e[247:240] = 8'h1f; e[255:248] = 8'h80;
    push_p(0, e, 1'b1, 1'b1); push_s(0, 1'b1, 16'd1);
    send(m, 0);
    squeeze(0, 0, 1'b1);

    // 31-byte message: both pad bytes merge into byte 31.
    m = {}; e = '0;
    for (int i = 0; i < 31; i++) begin m.push_back(8'(i + 1)); e[8*i +: 8] = 8'(i + 1); end
    e[255:248] = 8'h9f;
    push_p(0, e, 1'b1, 1'b1); push_s(0, 1'b1, 16'd1);
    send(m, 0);
    squeeze(0, 0, 1'b1);

    // 32-byte message: data block, then a pad-only block; consumer stalls 10 cycles with stray perm_done.
    m = {}; e = '0;
    for (int i = 0; i < 32; i++) begin m.push_back(8'(i + 1)); e[8*i +: 8] = 8'(i + 1); end
    push_p(0, e, 1'b1, 1'b1);
    e = '0; e[7:0] = 8'h1f; e[255:248] = 8'h80;
    push_p(0, e, 1'b0, 1'b1); push_s(0, 1'b1, 16'd2);
    send(m, 0);
    squeeze(0, 10, 1'b1);

    // clear during PERM, then a stray perm_done from the core.
    e = '0; e[7:0] = 8'h55; e[15:8] = 8'h1f; e[255:248] = 8'h80;
    push_p(0, e, 1'b1, 1'b1);
    m = {8'h55};
    send(m, 0);
    b = 0;
    while (perm_start !== 1'b1 && b < 20) begin @(posedge clk); #1; b++; end
    chk("perm_start_wait", b < 20, 1'b1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    chk_reset();
    clear = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk_reset();

    // 1-byte message after the abandoned one.
    e = '0; e[7:0] = 8'haa; e[15:8] = 8'h1f; e[255:248] = 8'h80;
    push_p(0, e, 1'b1, 1'b1); push_s(0, 1'b1, 16'd1);
    m = {8'haa};
    send(m, 0);
    squeeze(0, 0, 1'b1);

    // Two squeeze blocks: second output comes from a zero-block, non-absorbing permutation.
    e = '0; e[7:0] = 8'h11; e[15:8] = 8'h22; e[23:16] = 8'h1f; e[255:248] = 8'h80;
    push_p(1, e, 1'b1, 1'b1); push_s(1, 1'b0, 16'd1);
    push_p(1, '0, 1'b0, 1'b0); push_s(1, 1'b1, 16'd1);
    m = {8'h11, 8'h22};
    send(m, 1);
    squeeze(1, 0, 1'b0);
    squeeze(1, 0, 1'b1);

    b = 0;
    while (q.size() != 0 && b < 200) begin @(posedge clk); b++; end
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
